hilo_muldiv_unit: RTL and testbench

//   Multi-cycle multiply/divide engine and owner of the Hi/Lo register pair.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 31 +++
 rtl/hilo_muldiv_unit.sv | 135 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = $clog2(ITERS);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MSUB  = 3'd3,
        OP_DIV   = 3'd4,
        OP_DIVU  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic is_signed_op(input op_e op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

    function automatic logic is_move_op(input op_e op);
        return op inside {OP_MTHI, OP_MTLO};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply and restoring divide on magnitudes.
module muldiv_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   divisor,
    input  logic [2*W-1:0] prod,
    input  logic [W-1:0]   rem,
    input  logic [W-1:0]   quo,
    output logic [2*W-1:0] prod_nxt,
    output logic [W-1:0]   rem_nxt,
    output logic [W-1:0]   quo_nxt
);

    logic [W:0] sum;
    logic [W:0] shifted;
    logic       fits;

    always_comb begin
        // Multiplier sits in the low half and shifts out LSB-first.
        sum      = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {sum, prod[W-1:1]};

        // 33-bit partial remainder: previous remainder plus next dividend bit.
        shifted  = {rem, quo[W-1]};
        fits     = (shifted >= {1'b0, divisor});
        rem_nxt  = W'(fits ? (shifted - {1'b0, divisor}) : shifted);
        quo_nxt  = {quo[W-2:0], fits};
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the architectural Hi/Lo pair.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned        DATA_W  = 32,
    parameter logic [DATA_W-1:0]  DIV0_LO = 32'hFFFFFFFF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    output logic [2*DATA_W-1:0]   HiLo,
    output logic                  Busy,
    output logic                  Done
);

    localparam int unsigned W = DATA_W;

    state_e           state, state_nxt;
    op_e              op_in, op_q;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_q, b_q;
    logic             neg_res, neg_rem;
    logic [2*W-1:0]   snap, prod, prod_nxt;
    logic [W-1:0]     rem, rem_nxt, quo, quo_nxt;

    logic             start_iter, start_move, sgn;
    logic [W-1:0]     a_abs, b_abs;
    logic [2*W-1:0]   prod_fix, result, hilo_d;
    logic [W-1:0]     quo_fix, rem_fix;
    logic             hilo_we, done_d;

    assign op_in      = op_e'(Op);
    assign sgn        = is_signed_op(op_in);
    assign a_abs      = (sgn && A[W-1]) ? -A : A;
    assign b_abs      = (sgn && B[W-1]) ? -B : B;
    assign start_iter = (state == IDLE) && Start && !is_move_op(op_in);
    assign start_move = (state == IDLE) && Start &&  is_move_op(op_in);

    muldiv_step #(.W(W)) u_step (
        .mcand    (a_q),
        .divisor  (b_q),
        .prod     (prod),
        .rem      (rem),
        .quo      (quo),
        .prod_nxt (prod_nxt),
        .rem_nxt  (rem_nxt),
        .quo_nxt  (quo_nxt)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_iter) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(ITERS - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign fix-up and final Hi/Lo value, consumed only in FIX.
    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -quo  : quo;
        rem_fix  = neg_rem ? -rem  : rem;
        case (op_q)
            OP_MADD: result = snap + prod_fix;
            OP_MSUB: result = snap - prod_fix;
            OP_DIV,
            OP_DIVU: result = {rem_fix, (b_q == '0) ? DIV0_LO : quo_fix};
            default: result = prod_fix;
        endcase
    end

    always_comb begin
        Busy    = (state != IDLE);
        hilo_we = 1'b0;
        done_d  = 1'b0;
        hilo_d  = HiLo;
        if (start_move) begin
            hilo_we = 1'b1;
            done_d  = 1'b1;
            hilo_d  = (op_in == OP_MTHI) ? {A, HiLo[W-1:0]} : {HiLo[2*W-1:W], A};
        end else if (state == FIX) begin
            hilo_we = 1'b1;
            done_d  = 1'b1;
            hilo_d  = result;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            HiLo    <= '0;
            Done    <= 1'b0;
            op_q    <= OP_MULT;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            snap    <= '0;
            prod    <= '0;
            rem     <= '0;
            quo     <= '0;
        end else begin
            Done <= done_d;
            if (hilo_we) HiLo <= hilo_d;
            if (start_iter) begin
                op_q    <= op_in;
                a_q     <= a_abs;
                b_q     <= b_abs;
                neg_res <= sgn && (A[W-1] ^ B[W-1]);
                neg_rem <= sgn && A[W-1];
                snap    <= HiLo;
                cnt     <= '0;
                prod    <= {W'(0), b_abs};
                rem     <= '0;
                quo     <= a_abs;
            end else if (state == CALC) begin
                cnt  <= cnt + CNT_W'(1);
                prod <= prod_nxt;
                rem  <= rem_nxt;
                quo  <= quo_nxt;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed, table-driven bench for hilo_muldiv_unit.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset, Start;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic [63:0] HiLo;
    logic        Busy, Done;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    hilo_muldiv_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .HiLo  (HiLo),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        logic [63:0] pre;
        int busy_cnt, cyc, exp_busy;
        logic held;
        @(negedge Clk);
        Op = op; A = a; B = b; Start = 1'b1;
        pre = HiLo;
        @(posedge Clk); #1;
        Start = 1'b0;
        busy_cnt = 0; cyc = 0; held = 1'b1;
        while (!Done && cyc < 100) begin
            if (Busy) busy_cnt++;
            if (HiLo !== pre) held = 1'b0;
            @(posedge Clk); #1;
            cyc++;
        end
        exp_busy = (op >= 3'd6) ? 0 : 33;
        chk({name, " done"}, 64'(Done), 64'd1);
        chk({name, " hilo"}, HiLo, exp);
        chk({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
        if (exp_busy != 0) chk({name, " hilo held"}, 64'(held), 64'd1);
        @(posedge Clk); #1;
        chk({name, " done single"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int cyc, done_cnt;

        vecs[0]  = '{3'(OP_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[1]  = '{3'(OP_MULT),  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB};
        vecs[2]  = '{3'(OP_MADD),  32'd2,        32'd3,        64'hFFFFFFFF_FFFFFFF1};
        vecs[3]  = '{3'(OP_MSUB),  32'd1,        32'd1,        64'hFFFFFFFF_FFFFFFF0};
        vecs[4]  = '{3'(OP_DIV),   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD};
        vecs[5]  = '{3'(OP_DIVU),  32'd100,      32'd7,        64'h00000002_0000000E};
        vecs[6]  = '{3'(OP_DIV),   32'd5,        32'd0,        64'h00000005_FFFFFFFF};
        vecs[7]  = '{3'(OP_DIV),   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
        vecs[8]  = '{3'(OP_MTHI),  32'h12345678, 32'd0,        64'h12345678_80000000};
        vecs[9]  = '{3'(OP_MTLO),  32'h9ABCDEF0, 32'd0,        64'h12345678_9ABCDEF0};
        vecs[10] = '{3'(OP_MULT),  32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
        vecs[11] = '{3'(OP_DIV),   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
        vecs[12] = '{3'(OP_MADD),  32'hFFFFFFFF, 32'd1,        64'h00000001_FFFFFFFC};
        vecs[13] = '{3'(OP_DIVU),  32'hFFFFFFFF, 32'd0,        64'hFFFFFFFF_FFFFFFFF};

        Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset hilo", HiLo, 64'd0);
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset done", 64'(Done), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Start during CALC is ignored; Start in the Done cycle is accepted.
        @(negedge Clk);
        Op = 3'(OP_MULT); A = 32'd3; B = 32'd4; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Op = 3'(OP_DIVU); A = 32'd100; B = 32'd7; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        cyc = 0;
        while (!Done && cyc < 100) begin
            @(posedge Clk); #1;
            cyc++;
        end
        chk("busy ignore done", 64'(Done), 64'd1);
        chk("busy ignore hilo", HiLo, 64'd12);
        Op = 3'(OP_DIVU); A = 32'd100; B = 32'd7; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("done-cycle start busy", 64'(Busy), 64'd1);
        chk("done pulses once", 64'(Done), 64'd0);
        cyc = 0;
        while (!Done && cyc < 100) begin
            @(posedge Clk); #1;
            cyc++;
        end
        chk("done-cycle start done", 64'(Done), 64'd1);
        chk("done-cycle start hilo", HiLo, 64'h00000002_0000000E);

        // Reset mid-divide aborts without a HiLo write or Done.
        @(negedge Clk);
        Op = 3'(OP_DIV); A = 32'hFFFFFF9C; B = 32'd3; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (15) @(posedge Clk);
        #1;
        chk("pre-reset busy", 64'(Busy), 64'd1);
        Reset = 1'b1;
        #1;
        chk("abort busy", 64'(Busy), 64'd0);
        chk("abort done", 64'(Done), 64'd0);
        chk("abort hilo", HiLo, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (Done) done_cnt++;
        end
        chk("post-abort done count", 64'(done_cnt), 64'd0);
        chk("post-abort hilo", HiLo, 64'd0);
        chk("post-abort busy", 64'(Busy), 64'd0);

        run_op("recover multu", 3'(OP_MULTU), 32'h00010000, 32'h00010000, 64'h00000001_00000000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
